// File: rtl/spi_slave_frame_if.sv
// SPI pins plus the register-wrapper side of the SPI slave frame decoder.
// The slave modport is the decoder's view; the master modport is the pad/wrapper side.
interface spi_slave_frame_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic       rw_out;
    logic       addr_dv;
    logic       rxdv;
    logic [7:0] rx_d;
    logic [7:0] tx_d;
    logic       tx_en;

    modport slave (
        input  sclk, cs_n, mosi, tx_d, tx_en,
        output miso, miso_oe, reg_addr, rw_out, addr_dv, rxdv, rx_d
    );

    modport master (
        output sclk, cs_n, mosi, tx_d, tx_en,
        input  miso, miso_oe, reg_addr, rw_out, addr_dv, rxdv, rx_d
    );
endinterface

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave front end: oversamples sclk/cs_n/mosi with clk and decodes
// one {rw, addr[6:0]} byte followed by one data byte per cs_n assertion.
// Write frames pulse rxdv with the data byte; read frames shift tx_d out on miso.
module spi_slave_frame #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_slave_frame_if.slave   spi
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    // Synchroniser chains; cs_n idles high so its chain resets to all ones.
    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    // Fills with ones after reset; its top bit marks when the chains hold real pin values.
    logic [SYNC_STAGES-1:0] primed_q;

    logic sclkSync;
    logic csSync;
    logic mosiSync;
    logic primed;
    logic sclkRise;
    logic sclkFall;
    logic [7:0] rxByte;

    state_t     state_q,    state_d;
    logic [2:0] bitCnt_q,   bitCnt_d;
    logic [7:0] rxShift_q,  rxShift_d;
    logic [7:0] txShift_q,  txShift_d;
    logic       txLoaded_q, txLoaded_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic       rw_q,       rw_d;
    logic       addr_dv_q,  addr_dv_d;
    logic [7:0] rx_d_q,     rx_d_d;
    logic       rxdv_q,     rxdv_d;
    logic       miso_q,     miso_d;
    logic       sclkPrev_q, sclkPrev_d;
    logic       armed_q,    armed_d;

    assign sclkSync = sclkSync_q[SYNC_STAGES-1];
    assign csSync   = csSync_q[SYNC_STAGES-1];
    assign mosiSync = mosiSync_q[SYNC_STAGES-1];
    assign primed   = primed_q[SYNC_STAGES-1];

    assign sclkRise = sclkSync & ~sclkPrev_q;
    assign sclkFall = ~sclkSync & sclkPrev_q;
    assign rxByte   = {rxShift_q[6:0], mosiSync};

    assign spi.miso     = miso_q;
    assign spi.miso_oe  = ~csSync;
    assign spi.reg_addr = reg_addr_q;
    assign spi.rw_out   = rw_q;
    assign spi.addr_dv  = addr_dv_q;
    assign spi.rxdv     = rxdv_q;
    assign spi.rx_d     = rx_d_q;

    // Bring the asynchronous SPI pins into the clk domain through equal-depth chains
    // so mosi stays aligned with the sclk edge it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            primed_q   <= '0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi.sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], spi.cs_n};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi.mosi};
            primed_q   <= {primed_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Frame state, shift registers and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= 3'd0;
            rxShift_q  <= 8'h00;
            txShift_q  <= 8'h00;
            txLoaded_q <= 1'b0;
            reg_addr_q <= 7'h00;
            rw_q       <= 1'b0;
            addr_dv_q  <= 1'b0;
            rx_d_q     <= 8'h00;
            rxdv_q     <= 1'b0;
            miso_q     <= 1'b0;
            sclkPrev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            txLoaded_q <= txLoaded_d;
            reg_addr_q <= reg_addr_d;
            rw_q       <= rw_d;
            addr_dv_q  <= addr_dv_d;
            rx_d_q     <= rx_d_d;
            rxdv_q     <= rxdv_d;
            miso_q     <= miso_d;
            sclkPrev_q <= sclkPrev_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state logic: byte decode per state, then cs_n release overrides everything.
    // armed_q blocks frame start after a reset until cs_n has been seen high, so a
    // frame already in progress at reset release is never partially decoded.
    // In a read data phase the fall right after the last address bit is skipped
    // (bitCnt_q == 0) because tx_d[7] must stay on miso for the first data rise.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        txLoaded_d = txLoaded_q;
        reg_addr_d = reg_addr_q;
        rw_d       = rw_q;
        addr_dv_d  = addr_dv_q;
        rx_d_d     = rx_d_q;
        rxdv_d     = 1'b0;
        miso_d     = miso_q;
        sclkPrev_d = sclkSync;
        armed_d    = armed_q | (primed & csSync);

        case (state_q)
            IDLE: begin
                bitCnt_d   = 3'd0;
                miso_d     = 1'b0;
                txLoaded_d = 1'b0;
                if (armed_q && !csSync) begin
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (sclkRise) begin
                    rxShift_d = rxByte;
                    bitCnt_d  = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        reg_addr_d = rxByte[6:0];
                        rw_d       = rxByte[7];
                        addr_dv_d  = 1'b1;
                        txShift_d  = 8'h00;
                        txLoaded_d = 1'b0;
                        state_d    = DATA;
                    end
                end
            end

            DATA: begin
                if (!rw_q) begin
                    if (sclkRise) begin
                        rxShift_d = rxByte;
                        bitCnt_d  = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            rx_d_d  = rxByte;
                            rxdv_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end else begin
                    if (sclkRise) begin
                        if (!txLoaded_q) begin
                            txLoaded_d = 1'b1;
                            txShift_d  = 8'h00;
                            miso_d     = 1'b0;
                        end
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            miso_d  = 1'b0;
                            state_d = DONE;
                        end
                    end else if (!txLoaded_q && spi.tx_en) begin
                        txLoaded_d = 1'b1;
                        txShift_d  = spi.tx_d;
                        miso_d     = spi.tx_d[7];
                    end else if (sclkFall && txLoaded_q && (bitCnt_q != 3'd0)) begin
                        txShift_d = {txShift_q[6:0], 1'b0};
                        miso_d    = txShift_q[6];
                    end
                end
            end

            DONE: begin
                miso_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && csSync) begin
            state_d    = IDLE;
            bitCnt_d   = 3'd0;
            addr_dv_d  = 1'b0;
            rw_d       = 1'b0;
            miso_d     = 1'b0;
            rxdv_d     = 1'b0;
            txLoaded_d = 1'b0;
        end
    end

endmodule
